nibble_serial_accumulator: RTL and testbench
============================================

// Module: nibble_serial_accumulator
// PURPOSE
//  Slice-serial multiply-accumulate stage downstream of mux8to1. Drives the mux Sel
//  input to sweep activation slices In1..In7 (LS slice first) and consumes the
//  selected INPUT_WIDTH-bit slice each cycle. Each slice is multiplied by a latched
//  operand and shift-accumulated, so precision (1..7 slices) is chosen per operation.
//  Supports result chaining across operations for dot products.
// PARAMETERS
//  INPUT_WIDTH  4   slice width; must match mux8to1 INPUT_WIDTH
//  IDX_WIDTH    3   Sel / slice-count width; must match mux8to1 Sel
//  OPB_WIDTH    8   unsigned multiplicand width
//  ACC_WIDTH    48  accumulator/result width; arithmetic is modulo 2^ACC_WIDTH
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            async active-low reset
//  start        in   1            request new operation; sampled in IDLE only
//  num_slices   in   IDX_WIDTH    slices to process, 0..7; latched at start
//  accumulate   in   1            1: seed from current result; 0: seed 0; latched
//  op_b         in   OPB_WIDTH    unsigned multiplicand; latched at start
//  sel          out  IDX_WIDTH    slice index to mux8to1 Sel
//  nib_in       in   INPUT_WIDTH  mux8to1 Out; used combinationally in same cycle
//  busy         out  1            high in RUN
//  done         out  1            one-cycle pulse in DONE; result final
//  result       out  ACC_WIDTH    unsigned accumulated result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; sel, busy, done, result, internal acc and
//   latched operands = 0. Deassertion takes effect at the next clk edge.
//  FSM: IDLE -> RUN on start=1 and num_slices!=0; IDLE -> DONE on start=1 and
//   num_slices==0; RUN -> DONE at the edge ending the slice with sel==num_slices-1;
//   DONE -> IDLE unconditionally after one cycle.
//  Timing: start sampled at edge t. RUN occupies cycles t+1..t+n. In cycle t+k,
//   sel=k-1. DONE is cycle t+n+1, so done latency is n+1 cycles from the start edge.
//  Per RUN cycle: acc += ({nib_in*op_b_l} zero-extended) << (INPUT_WIDTH*sel).
//   Product width is INPUT_WIDTH+OPB_WIDTH. Sum truncates mod 2^ACC_WIDTH, with no
//   saturation or flag.
//  Seed at start edge: acc = accumulate ? result : 0.
//  result is written once, at the RUN->DONE edge, or the IDLE->DONE edge for n=0.
//   It holds until the next completion. It is valid during and after done.
//  n=0: no slices read, sel stays 0; result = seed (0, or prior result if
//   accumulate=1).
//  sel = 0 in IDLE and DONE. It increments by 1 per RUN cycle and never exceeds 6.
//   Value 7 is never driven.
//  start in RUN or DONE is ignored, with no queuing. Same-cycle start with DONE is
//   also ignored. A new op needs start in IDLE.
//  nib_in, num_slices, op_b and accumulate changes after the start edge do not affect
//   the operation in flight, except nib_in, which is read live each RUN cycle.
// TESTING
//  1 n=2, nib In1=5 In2=3, op_b=10, acc=0 -> sel 0,1; done at t+3; result=530.
//  2 n=7, all slices 0xF, op_b=0xFF, acc=0 -> done at t+8; result=0xFEFFFFF01.
//  3 repeat test 1 with accumulate=1 right after it -> result=1060.
//  4 n=0, acc=0 after test 3 -> busy never high; done at t+1; result=0; sel stays 0.
//  5 n=5, assert rst_n=0 mid-RUN after 2 slices -> all outputs 0 immediately; a new
//    n=1 op (nib=7, op_b=2) then gives result=14.
//  6 hold start=1 throughout an n=3 op (nib=1 each, op_b=1) -> no restart during
//    RUN or DONE; result=0x111; a second op starts only from IDLE.

Source files
------------

// File: rtl/nibble_serial_accumulator.sv
// -----------------------------------------------------------------------------
// nibble_serial_accumulator
//
// Slice-serial multiply-accumulate stage. It sits after an 8:1 slice mux. The
// block drives the mux select to walk the activation slices in order, least
// significant first. Each selected INPUT_WIDTH-bit slice is multiplied by a
// multiplicand latched at start, shifted to its slice position and added into
// a wide accumulator. The number of slices (0..7) is chosen per operation.
// With accumulate=1 the accumulator starts from the previous result, so a
// series of operations can build up a dot product.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request a new operation (only sampled in IDLE)
//   num_slices  in   number of slices to process, 0..7 (latched at start)
//   accumulate  in   1: seed from the current result, 0: seed from zero
//   op_b        in   unsigned multiplicand (latched at start)
//   sel         out  slice index sent to the mux select
//   nib_in      in   selected slice from the mux, used in the same cycle
//   busy        out  high while slices are being consumed (RUN)
//   done        out  one-cycle pulse; result is final while it is high
//   result      out  unsigned accumulated result, modulo 2^ACC_WIDTH
//
// Handshake: start is a level request. It is only accepted in IDLE, with no
// queuing. A start that arrives in RUN or DONE is dropped, and so is a start
// in the cycle that leaves DONE. A held start therefore launches a new
// operation once the block is back in IDLE. done is a pulse, not a level.
// result stays valid from done until the next completion.
// -----------------------------------------------------------------------------
module nibble_serial_accumulator #(
    parameter int INPUT_WIDTH = 4,
    parameter int IDX_WIDTH   = 3,
    parameter int OPB_WIDTH   = 8,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [IDX_WIDTH-1:0]   num_slices,
    input  logic                   accumulate,
    input  logic [OPB_WIDTH-1:0]   op_b,
    output logic [IDX_WIDTH-1:0]   sel,
    input  logic [INPUT_WIDTH-1:0] nib_in,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_WIDTH-1:0]   result
);

    localparam int PROD_WIDTH = INPUT_WIDTH + OPB_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]             state_q,  state_d;
    logic [IDX_WIDTH-1:0]   sel_q,    sel_d;
    logic [IDX_WIDTH-1:0]   num_q,    num_d;
    logic [OPB_WIDTH-1:0]   op_b_q,   op_b_d;
    logic [ACC_WIDTH-1:0]   acc_q,    acc_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;

    // -------------------------------------------------------------------------
    // Slice product, aligned to the slice position
    // -------------------------------------------------------------------------
    logic [PROD_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]  product_ext;
    logic [31:0]           shift_amt;
    logic [ACC_WIDTH-1:0]  slice_term;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [ACC_WIDTH-1:0]  seed;
    logic                  last_slice;

    always_comb begin
        product     = PROD_WIDTH'(nib_in) * PROD_WIDTH'(op_b_q);
        product_ext = ACC_WIDTH'(product);
        shift_amt   = 32'(sel_q) * 32'(INPUT_WIDTH);
        // Any bits shifted past the top of the accumulator are lost. This is
        // the modulo 2^ACC_WIDTH behaviour the result is defined to have.
        slice_term  = product_ext << shift_amt;
        acc_sum     = acc_q + slice_term;
        seed        = accumulate ? result_q : '0;
        // num_q is never 0 in RUN, so num_q-1 does not wrap there.
        last_slice  = (sel_q == (num_q - IDX_WIDTH'(1)));
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        num_d    = num_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (start) begin
                    num_d  = num_slices;
                    op_b_d = op_b;
                    acc_d  = seed;
                    if (num_slices == '0) begin
                        // Zero-length operation: nothing to read, so the
                        // seed itself becomes the result right away.
                        result_d = seed;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                acc_d = acc_sum;
                if (last_slice) begin
                    // Publish the total that includes this final slice, and
                    // park sel at 0 so the index never reaches 7.
                    result_d = acc_sum;
                    sel_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    sel_d = sel_q + IDX_WIDTH'(1);
                end
            end

            ST_DONE: begin
                // Start is ignored here, even when it stays high.
                sel_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            num_q    <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            num_q    <= num_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sel    = sel_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_accumulator
//
// Bench for nibble_serial_accumulator. The slice mux is modelled as an array
// indexed by sel. A timeline model follows each operation from its start edge:
// it tracks the cycles since start and computes the expected result as
// seed + op_b * (the value formed by the first n slices). The compare process
// checks every output at every negedge. Directed operations pin the model
// against hand-computed values, and randomized operations follow them.
// -----------------------------------------------------------------------------
module tb_nibble_serial_accumulator;

    localparam int IW = 4;
    localparam int XW = 3;
    localparam int BW = 8;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start;
    logic [XW-1:0] num_slices;
    logic          accumulate;
    logic [BW-1:0] op_b;
    logic [XW-1:0] sel;
    logic [IW-1:0] nib_in;
    logic          busy;
    logic          done;
    logic [AW-1:0] result;

    // Index 0 is In1 (least significant slice), index 6 is In7.
    logic [IW-1:0] slices [0:7];

    assign nib_in = slices[sel];

    always #5 clk = ~clk;

    nibble_serial_accumulator #(
        .INPUT_WIDTH(IW), .IDX_WIDTH(XW), .OPB_WIDTH(BW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_slices(num_slices),
        .accumulate(accumulate), .op_b(op_b), .sel(sel), .nib_in(nib_in),
        .busy(busy), .done(done), .result(result)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    bit            m_active = 1'b0;
    int            m_k = 0;
    int            m_n = 0;
    logic [AW-1:0] m_final = '0;
    logic [AW-1:0] m_result = '0;
    logic [AW-1:0] exp_q[$];

    function automatic logic [AW-1:0] ref_result(input logic [AW-1:0] seed, input int n,
                                                 input logic [BW-1:0] b);
        logic [63:0] val;
        logic [63:0] tot;
        val = 64'd0;
        for (int k = 0; k < n; k++) val = val + (64'(slices[k]) << (IW * k));
        tot = 64'(seed) + 64'(b) * val;
        return tot[AW-1:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_k      = 0;
                m_n      = 0;
                m_result = '0;
                exp_q.delete();
            end else if (m_active) begin
                m_k++;
                if (m_k == m_n + 1) m_result = m_final;
                else if (m_k > m_n + 1) m_active = 1'b0;
            end else if (start) begin
                m_n     = int'(num_slices);
                m_final = ref_result(accumulate ? m_result : '0, m_n, op_b);
                exp_q.push_back(m_final);
                m_active = 1'b1;
                m_k      = 1;
                if (m_n == 0) m_result = m_final;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare process
    // -------------------------------------------------------------------------
    initial begin
        bit exp_busy;
        bit exp_done;
        int exp_sel;
        forever begin
            @(negedge clk);
            exp_busy = m_active && (m_k <= m_n);
            exp_done = m_active && (m_k == m_n + 1);
            exp_sel  = exp_busy ? m_k - 1 : 0;
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("sel", 64'(sel), 64'(exp_sel));
            check("result", 64'(result), 64'(m_result));
            if (done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL done_queue: got done=1 expected no pending op at %0t", $time);
                end else begin
                    check("done_result", 64'(result), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks (entered at #1 after a posedge, with the DUT in IDLE)
    // -------------------------------------------------------------------------
    task automatic wait_done(input string tag, output logic [AW-1:0] res,
                             output int lat, output bit saw_busy);
        bit got;
        got      = 1'b0;
        lat      = 0;
        res      = '0;
        saw_busy = 1'b0;
        while (!got && lat < 20) begin
            lat++;
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (done) begin
                got = 1'b1;
                res = result;
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input int n, input bit acc, input logic [BW-1:0] b,
                         output logic [AW-1:0] res, output int lat, output bit saw_busy);
        num_slices = XW'(n);
        accumulate = acc;
        op_b       = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        // Scramble latched inputs; the operation in flight must not notice.
        start      = 1'b0;
        num_slices = XW'($urandom_range(0, 7));
        op_b       = BW'($urandom);
        accumulate = 1'($urandom_range(0, 1));
        wait_done(tag, res, lat, saw_busy);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [AW-1:0] res;
        int            lat;
        bit            saw_busy;
        int            n;
        bit            acc;
        logic [BW-1:0] b;

        start      = 1'b0;
        num_slices = '0;
        accumulate = 1'b0;
        op_b       = '0;
        for (int i = 0; i < 8; i++) slices[i] = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sel", 64'(sel), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two slices 5 and 3, times 10: 50 + 480.
        slices[0] = 4'd5;
        slices[1] = 4'd3;
        do_op("t1", 2, 1'b0, 8'd10, res, lat, saw_busy);
        check("t1_result", 64'(res), 64'd530);
        check("t1_latency", 64'(lat), 64'd3);

        // Same operation seeded from the previous result.
        do_op("t3", 2, 1'b1, 8'd10, res, lat, saw_busy);
        check("t3_result", 64'(res), 64'd1060);

        // Zero slices, seed 0: done in the first cycle, no RUN at all.
        do_op("t4", 0, 1'b0, 8'd99, res, lat, saw_busy);
        check("t4_result", 64'(res), 64'd0);
        check("t4_latency", 64'(lat), 64'd1);
        check("t4_busy_seen", 64'(saw_busy), 64'd0);

        // All seven slices 0xF times 0xFF.
        for (int i = 0; i < 8; i++) slices[i] = 4'hF;
        do_op("t2", 7, 1'b0, 8'hFF, res, lat, saw_busy);
        check("t2_result", 64'(res), 64'hF_EFFF_FF01);
        check("t2_latency", 64'(lat), 64'd8);

        // Zero slices with accumulate returns the prior result unchanged.
        do_op("t2b", 0, 1'b1, 8'h12, res, lat, saw_busy);
        check("t2b_result", 64'(res), 64'hF_EFFF_FF01);

        // Reset in the middle of a five-slice operation.
        for (int i = 0; i < 8; i++) slices[i] = IW'($urandom);
        num_slices = 3'd5;
        op_b       = 8'd77;
        accumulate = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_midrun_busy", 64'(busy), 64'd1);
        check("t5_midrun_sel", 64'(sel), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_sel", 64'(sel), 64'd0);
        check("t5_rst_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        slices[0] = 4'd7;
        do_op("t5", 1, 1'b0, 8'd2, res, lat, saw_busy);
        check("t5_result", 64'(res), 64'd14);
        check("t5_latency", 64'(lat), 64'd2);

        // start held high across a three-slice operation.
        slices[0]  = 4'd1;
        slices[1]  = 4'd1;
        slices[2]  = 4'd1;
        num_slices = 3'd3;
        op_b       = 8'd1;
        accumulate = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3) check("t6_busy_c3", 64'(busy), 64'd1);
            if (c == 4) begin
                check("t6_done_c4", 64'(done), 64'd1);
                check("t6_result_c4", 64'(result), 64'h111);
            end
            if (c == 5) begin
                check("t6_idle_busy_c5", 64'(busy), 64'd0);
                check("t6_idle_done_c5", 64'(done), 64'd0);
            end
            if (c == 6) check("t6_restart_busy_c6", 64'(busy), 64'd1);
            if (c == 9) begin
                check("t6_done_c9", 64'(done), 64'd1);
                check("t6_result_c9", 64'(result), 64'h111);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Randomized operations.
        for (int op = 0; op < 40; op++) begin
            for (int i = 0; i < 8; i++) slices[i] = IW'($urandom);
            n   = int'($urandom_range(0, 7));
            acc = 1'($urandom_range(0, 1));
            b   = BW'($urandom);
            do_op("rand", n, acc, b, res, lat, saw_busy);
            check("rand_latency", 64'(lat), 64'(n + 1));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule
